pack_iq: RTL and testbench
==========================

# pack_iq

Transmit-side counterpart of the receive IQ splitter. It accepts independent I and Q AXI-Stream component streams, pairs them one-to-one in arrival order, and sign-extends and rescales each component. It emits a single packed IQ AXI-Stream word with I in the upper half and Q in the lower half, with full tready backpressure. It sits between the modulator's I/Q outputs and the DAC/DUC interface, which consumes packed IQ.

## Interface
- I_WIDTH, 16, width of each input component (signed).
- O_WIDTH, 48, packed output width; each component is O_WIDTH/2. Elaboration error if O_WIDTH is odd or I_WIDTH + LSB_SHIFT_BITS > O_WIDTH/2.
- LSB_SHIFT_BITS, 4, left shift applied after sign extension; restores the scale removed on the receive side.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- I_tdata  in  I_WIDTH  signed I sample.
- I_tvalid  in  1  I sample valid.
- I_tready  out  1  I sample accepted when I_tvalid && I_tready.
- Q_tdata  in  I_WIDTH  signed Q sample.
- Q_tvalid  in  1  Q sample valid.
- Q_tready  out  1  Q sample accepted when Q_tvalid && Q_tready.
- IQ_tdata  out  O_WIDTH  packed sample: {I_ext, Q_ext}.
- IQ_tvalid  out  1  packed sample valid.
- IQ_tready  in  1  downstream accepts when IQ_tvalid && IQ_tready.
- skew_err  out  1  sticky flag: channels have drifted a full buffer apart.

## Operation
- Each channel has a 2-entry FIFO.
  - Push on tvalid && tready.
  - tready = (count != 2), derived from registered count only; there is no pop-through when full.
- Pair condition: both FIFOs non-empty AND (IQ_tvalid == 0 OR IQ_tready == 1).
- On a pair:
  - Pop both heads in the same cycle.
  - Load the output register with {sext(I_head) <<< LSB_SHIFT_BITS, sext(Q_head) <<< LSB_SHIFT_BITS}.
  - Each component is sign-extended to O_WIDTH/2 and then shifted. Vacated LSBs are zero. The width constraint guarantees no overflow.
- Output register handling:
  - IQ_tvalid sets on load.
  - IQ_tvalid clears on an accept with no new pair.
  - IQ_tdata is held stable while IQ_tvalid && !IQ_tready.
- Pairing is strictly FIFO order; the block never drops or reorders samples.
- If one channel runs ahead, its FIFO fills and its tready deasserts until the other channel catches up.
- skew_err sets at any clock edge where one FIFO has count 2 and the other has count 0. It is cleared only by rst_n.
- Simultaneous push and pop on the same FIFO in one cycle: count is unchanged and both operations take effect.

## Timing
- Reset values (async assert, synchronous release via rst_n deassertion):
  - FIFO counts 0.
  - IQ_tvalid 0, IQ_tdata 0.
  - skew_err 0.
  - I_tready and Q_tready 1 as soon as rst_n = 1.
- Latency: both components accepted at edge N → IQ_tvalid = 1 after edge N+1, assuming an empty output register or IQ_tready = 1.
- Throughput: one packed sample per cycle sustained while both inputs are valid and IQ_tready = 1.
- Reset mid-operation: all buffered and output data is discarded immediately and IQ_tvalid drops asynchronously.
- IQ_tvalid is never combinationally dependent on IQ_tready.
- I_tready and Q_tready are registered-state functions only, with no input-to-output combinational paths.

## Structure
- Shared package `iq_pkg` holds:
  - the component-width helper (O_WIDTH/2);
  - the elaboration-time width legality check;
  - the sign-extend-and-shift function, which the receive-side truncation block also uses, so both directions agree on the format.
- One sub-module, `iq_fifo2`: a parameterised 2-entry FIFO with count, full, empty, push and pop. It is instantiated once for I and once for Q.
- The top level contains the pair logic, the output register and skew_err.

## Test plan
- Default parameters, I = 16'h0001 and Q = 16'h8000 presented together, IQ_tready = 1 → IQ_tdata = 48'h000010_F80000 one cycle after acceptance.
- Stream 8 I samples before any Q → I_tready drops after 2 accepts; skew_err = 1; Q samples 0..7 then pair in order with I samples 0..1 first, and later I samples are accepted as space frees.
- Both inputs valid every cycle with IQ_tready toggling 1,0,1,0 → IQ_tdata stable across each stall, no loss or duplication, and the output count equals the input count.
- I arrives 3 cycles after Q for a single sample → exactly one IQ word, and skew_err stays 0.
- Assert rst_n = 0 with both FIFOs full and IQ_tvalid = 1 → IQ_tvalid = 0 and skew_err = 0 immediately; after release the first new pair outputs correctly with no stale data.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared IQ sample-format helpers used by both the transmit packer and the
// receive-side truncation block, so both directions agree on the scaling.
package iq_pkg;

  // Widest component the sign-extend helper can produce.
  localparam int SX_W = 64;

  function automatic int comp_width(input int o_width);
    return o_width / 2;
  endfunction

  function automatic bit widths_legal(input int i_w, input int o_w, input int sh);
    return (i_w > 0) && (sh >= 0) && ((o_w % 2) == 0) &&
           ((i_w + sh) <= (o_w / 2)) && ((o_w / 2) <= SX_W);
  endfunction

  // Sign-extend the low i_w bits of din, then shift left by sh (zero fill).
  function automatic logic [SX_W-1:0] sext_shift(input logic [SX_W-1:0] din,
                                                 input int i_w, input int sh);
    logic signed [SX_W-1:0] v;
    v = $signed(din << (SX_W - i_w));
    v = v >>> (SX_W - i_w);
    return v << sh;
  endfunction

endpackage

// File: rtl/iq_fifo2.sv
// Two-entry FIFO with registered count; full/empty come from the count only,
// so ready derived from them has no combinational input dependence.
module iq_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // No pop-through: a push is refused when full even if a pop happens too.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pack_iq.sv
// Pairs independent I and Q AXI-Stream components in arrival order and emits
// one packed, sign-extended and rescaled IQ word {I_ext, Q_ext}.
module pack_iq
  import iq_pkg::*;
#(
  parameter int I_WIDTH        = 16,
  parameter int O_WIDTH        = 48,
  parameter int LSB_SHIFT_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [I_WIDTH-1:0] I_tdata,
  input  logic               I_tvalid,
  output logic               I_tready,
  input  logic [I_WIDTH-1:0] Q_tdata,
  input  logic               Q_tvalid,
  output logic               Q_tready,
  output logic [O_WIDTH-1:0] IQ_tdata,
  output logic               IQ_tvalid,
  input  logic               IQ_tready,
  output logic               skew_err
);

  localparam int CW = comp_width(O_WIDTH);

  if (!widths_legal(I_WIDTH, O_WIDTH, LSB_SHIFT_BITS)) begin : g_bad_width
    $error("pack_iq: O_WIDTH must be even and I_WIDTH + LSB_SHIFT_BITS <= O_WIDTH/2");
  end

  // Handshake: a beat transfers on a rising edge where tvalid && tready; a
  // source holds tdata stable while tvalid && !tready, and tvalid never waits
  // on tready.
  logic [I_WIDTH-1:0] w_i_head, w_q_head;
  logic [1:0]         w_i_count, w_q_count;
  logic               w_i_full, w_q_full, w_i_empty, w_q_empty;
  logic               w_pair;
  logic [CW-1:0]      w_i_ext, w_q_ext;
  logic [O_WIDTH-1:0] r_iq_data;
  logic               r_iq_valid;
  logic               r_skew;

  assign I_tready = !w_i_full;
  assign Q_tready = !w_q_full;

  iq_fifo2 #(.W(I_WIDTH)) u_i_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (I_tvalid && I_tready),
    .i_din   (I_tdata),
    .i_pop   (w_pair),
    .o_dout  (w_i_head),
    .o_count (w_i_count),
    .o_full  (w_i_full),
    .o_empty (w_i_empty)
  );

  iq_fifo2 #(.W(I_WIDTH)) u_q_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (Q_tvalid && Q_tready),
    .i_din   (Q_tdata),
    .i_pop   (w_pair),
    .o_dout  (w_q_head),
    .o_count (w_q_count),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign w_pair  = !w_i_empty && !w_q_empty && (!r_iq_valid || IQ_tready);
  assign w_i_ext = CW'(sext_shift(SX_W'(w_i_head), I_WIDTH, LSB_SHIFT_BITS));
  assign w_q_ext = CW'(sext_shift(SX_W'(w_q_head), I_WIDTH, LSB_SHIFT_BITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iq_data  <= '0;
      r_iq_valid <= 1'b0;
    end else if (w_pair) begin
      r_iq_data  <= {w_i_ext, w_q_ext};
      r_iq_valid <= 1'b1;
    end else if (IQ_tready) begin
      r_iq_valid <= 1'b0;
    end
  end

  // Sticky: one channel has a full buffer while the other has nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skew <= 1'b0;
    end else if ((w_i_count == 2'd2 && w_q_count == 2'd0) ||
                 (w_q_count == 2'd2 && w_i_count == 2'd0)) begin
      r_skew <= 1'b1;
    end
  end

  assign IQ_tdata  = r_iq_data;
  assign IQ_tvalid = r_iq_valid;
  assign skew_err  = r_skew;

endmodule

// File: tb/tb_pack_iq.sv
// Bench for pack_iq: directed scenarios feeding a negedge scoreboard that
// models the I/Q pairing and checks every packed output word in order.
module tb_pack_iq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] I_tdata = '0;
  logic        I_tvalid = 1'b0;
  logic        I_tready;
  logic [15:0] Q_tdata = '0;
  logic        Q_tvalid = 1'b0;
  logic        Q_tready;
  logic [47:0] IQ_tdata;
  logic        IQ_tvalid;
  logic        IQ_tready = 1'b1;
  logic        skew_err;

  int errors = 0;
  int checks = 0;
  int n_i_acc = 0;
  int n_q_acc = 0;
  int n_out = 0;

  logic [47:0] exp_q[$];
  logic [15:0] i_mq[$];
  logic [15:0] q_mq[$];
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data = '0;

  always #5 clk = ~clk;

  pack_iq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .I_tdata   (I_tdata),
    .I_tvalid  (I_tvalid),
    .I_tready  (I_tready),
    .Q_tdata   (Q_tdata),
    .Q_tvalid  (Q_tvalid),
    .Q_tready  (Q_tready),
    .IQ_tdata  (IQ_tdata),
    .IQ_tvalid (IQ_tvalid),
    .IQ_tready (IQ_tready),
    .skew_err  (skew_err)
  );

  function automatic logic [47:0] pack_exp(input logic [15:0] i, input logic [15:0] q);
    return {{4{i[15]}}, i, 4'h0, {4{q[15]}}, q, 4'h0};
  endfunction

  // Scoreboard: inputs are stable at negedge, so this sees exactly the
  // handshakes the next rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (IQ_tvalid !== 1'b1 || IQ_tdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%h, expected valid=1 data=%h",
                   IQ_tvalid, IQ_tdata, prev_data);
        end
      end
      prev_stall = IQ_tvalid && !IQ_tready;
      prev_data  = IQ_tdata;
      if (IQ_tvalid && IQ_tready) begin
        n_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h, expected no output", IQ_tdata);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          if (IQ_tdata !== e) begin
            errors++;
            $display("FAIL sb_data: got %h, expected %h", IQ_tdata, e);
          end
        end
      end
      if (I_tvalid && I_tready) begin
        i_mq.push_back(I_tdata);
        n_i_acc++;
      end
      if (Q_tvalid && Q_tready) begin
        q_mq.push_back(Q_tdata);
        n_q_acc++;
      end
      while (i_mq.size() > 0 && q_mq.size() > 0)
        exp_q.push_back(pack_exp(i_mq.pop_front(), q_mq.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ch=0 drives I, ch=1 drives Q; each sample is held until accepted.
  task automatic drive(input bit ch, input int n, input int pre);
    repeat (pre) step();
    for (int k = 0; k < n; k++) begin
      int  w;
      bit  acc;
      if (ch) begin
        Q_tdata = 16'($urandom_range(0, 65535));
        Q_tvalid = 1'b1;
      end else begin
        I_tdata = 16'($urandom_range(0, 65535));
        I_tvalid = 1'b1;
      end
      w = 0;
      acc = 1'b0;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = ch ? Q_tready : I_tready;
        step();
        w++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL drive_timeout: ch=%0d sample=%0d not accepted, expected accept", ch, k);
      end
    end
    if (ch) Q_tvalid = 1'b0;
    else I_tvalid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    IQ_tready = 1'b1;
    while ((exp_q.size() != 0 || IQ_tvalid) && w < 300) begin
      step();
      w++;
    end
    checks++;
    if (exp_q.size() != 0 || IQ_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drain: got pending=%0d valid=%0b, expected pending=0 valid=0",
               exp_q.size(), IQ_tvalid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (IQ_tvalid !== 1'b0 || IQ_tdata !== 48'h0 || skew_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b data=%h skew=%0b, expected 0 0 0",
               IQ_tvalid, IQ_tdata, skew_err);
    end
    #11;
    rst_n = 1'b1;
    #1;
    checks++;
    if (I_tready !== 1'b1 || Q_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got I=%0b Q=%0b, expected 1 1", I_tready, Q_tready);
    end
  endtask

  task automatic test_basic();
    step();
    IQ_tready = 1'b1;
    I_tdata = 16'h0001;
    Q_tdata = 16'h8000;
    I_tvalid = 1'b1;
    Q_tvalid = 1'b1;
    step();
    I_tvalid = 1'b0;
    Q_tvalid = 1'b0;
    step();
    checks++;
    if (IQ_tvalid !== 1'b1 || IQ_tdata !== 48'h000010_F80000) begin
      errors++;
      $display("FAIL basic_pack: got valid=%0b data=%h, expected valid=1 data=000010f80000",
               IQ_tvalid, IQ_tdata);
    end
    drain();
  endtask

  task automatic test_late_i();
    n_out = 0;
    fork
      drive(1'b1, 1, 0);
      drive(1'b0, 1, 3);
    join
    drain();
    checks++;
    if (n_out != 1 || skew_err !== 1'b0) begin
      errors++;
      $display("FAIL late_i: got words=%0d skew=%0b, expected words=1 skew=0", n_out, skew_err);
    end
  endtask

  task automatic test_stall();
    n_out = 0;
    n_i_acc = 0;
    n_q_acc = 0;
    IQ_tready = 1'b1;
    fork
      drive(1'b0, 10, 0);
      drive(1'b1, 10, 0);
      begin
        for (int c = 0; c < 40; c++) begin
          step();
          IQ_tready = ~IQ_tready;
        end
        IQ_tready = 1'b1;
      end
    join
    drain();
    checks++;
    if (n_out != 10 || n_i_acc != 10 || n_q_acc != 10) begin
      errors++;
      $display("FAIL stall_count: got out=%0d i=%0d q=%0d, expected 10 10 10",
               n_out, n_i_acc, n_q_acc);
    end
  endtask

  task automatic test_skew();
    n_out = 0;
    n_i_acc = 0;
    IQ_tready = 1'b1;
    fork
      drive(1'b0, 8, 0);
      begin
        repeat (6) step();
        checks++;
        if (I_tready !== 1'b0 || n_i_acc != 2) begin
          errors++;
          $display("FAIL skew_backpressure: got ready=%0b accepts=%0d, expected ready=0 accepts=2",
                   I_tready, n_i_acc);
        end
        checks++;
        if (skew_err !== 1'b1) begin
          errors++;
          $display("FAIL skew_flag: got %0b, expected 1", skew_err);
        end
        drive(1'b1, 8, 0);
      end
    join
    drain();
    checks++;
    if (n_out != 8) begin
      errors++;
      $display("FAIL skew_count: got %0d words, expected 8", n_out);
    end
  endtask

  task automatic test_reset_mid();
    IQ_tready = 1'b0;
    fork
      drive(1'b0, 3, 0);
      drive(1'b1, 3, 0);
    join
    checks++;
    if (IQ_tvalid !== 1'b1 || I_tready !== 1'b0 || Q_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill: got valid=%0b Irdy=%0b Qrdy=%0b, expected 1 0 0",
               IQ_tvalid, I_tready, Q_tready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (IQ_tvalid !== 1'b0 || skew_err !== 1'b0 || IQ_tdata !== 48'h0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b skew=%0b data=%h, expected 0 0 0",
               IQ_tvalid, skew_err, IQ_tdata);
    end
    exp_q.delete();
    i_mq.delete();
    q_mq.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    IQ_tready = 1'b1;
    step();
    I_tdata = 16'h7FFF;
    Q_tdata = 16'h0123;
    I_tvalid = 1'b1;
    Q_tvalid = 1'b1;
    step();
    I_tvalid = 1'b0;
    Q_tvalid = 1'b0;
    step();
    checks++;
    if (IQ_tvalid !== 1'b1 || IQ_tdata !== 48'h07FFF0_001230) begin
      errors++;
      $display("FAIL post_reset_pair: got valid=%0b data=%h, expected valid=1 data=07fff0001230",
               IQ_tvalid, IQ_tdata);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_late_i();
    test_stall();
    test_skew();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
